// File: rtl/fetch_pkg.sv
// Shared types and widths for the ProgramCounter fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_W    = 12;
  localparam int unsigned INSTR_W = 16;

  // Fixed encodings keep state values identical to the legacy design.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    ISSUE = ST_ISSUE,
    HALT  = ST_HALT
  } state_e;

  typedef logic [PC_W-1:0] pc_addr_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive FETCH cycles without an ack; flags the last allowed one.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = inc & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/pc_fetch_controller.sv
// Fetch/issue sequencer driving the ProgramCounter's we, cen and offset inputs.
module pc_fetch_controller #(
  parameter int unsigned PC_W    = fetch_pkg::PC_W,
  parameter int unsigned INSTR_W = fetch_pkg::INSTR_W,
  parameter int unsigned STEP    = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_cur,
  output logic               pc_we,
  output logic               pc_cen,
  output logic [PC_W-1:0]    pc_offset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_valid,
  input  logic [PC_W-1:0]    br_offset,
  input  logic               halt_req,
  output logic               halted,
  output logic               err
);

  import fetch_pkg::*;

  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               err_q, err_d;

  logic accept;
  logic tmo_inc, tmo_clr, tmo_expired;

  assign accept  = (state_q == ISSUE) & instr_ready;
  assign tmo_inc = (state_q == FETCH) & ~imem_ack;
  assign tmo_clr = (state_q != FETCH) | imem_ack;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end
      ISSUE: begin
        if (accept) begin
          state_d = halt_req ? HALT : FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // halt_req outranks br_valid; the PC's reset only takes effect while cen is high.
  assign pc_we       = accept & ~halt_req & ~rst;
  assign pc_offset   = pc_we ? (br_valid ? br_offset : STEP_V) : '0;
  assign pc_cen      = rst | pc_we;

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_cur;
  assign instr_valid = (state_q == ISSUE);
  assign instr_o     = instr_q;
  assign halted      = (state_q == HALT);
  assign err         = err_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller with a behavioural PC and instruction memory.
module tb_pc_fetch_controller;

  import fetch_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  pc_addr_t       pc_model;
  logic           pc_we, pc_cen;
  pc_addr_t       pc_offset;
  logic           imem_req;
  pc_addr_t       imem_addr;
  logic           imem_ack;
  logic [15:0]    imem_rdata;
  logic [15:0]    instr_o;
  logic           instr_valid, instr_ready;
  logic           br_valid;
  pc_addr_t       br_offset;
  logic           halt_req, halted, err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch_controller #(
    .PC_W    (12),
    .INSTR_W (16),
    .STEP    (1),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_model),
    .pc_we       (pc_we),
    .pc_cen      (pc_cen),
    .pc_offset   (pc_offset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_o     (instr_o),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_valid    (br_valid),
    .br_offset   (br_offset),
    .halt_req    (halt_req),
    .halted      (halted),
    .err         (err)
  );

  // ProgramCounter model: reset and add-offset update both gated by cen.
  always @(posedge clk) begin
    if (pc_cen) begin
      pc_model <= rst ? 12'd0 : pc_model + pc_offset;
    end
  end

  function automatic logic [15:0] word(input pc_addr_t a);
    return {4'hC, a};
  endfunction

  assign imem_rdata = imem_ack ? word(imem_addr) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    br_valid = 1'b0; br_offset = '0; halt_req = 1'b0;
    tick(); tick();
    #1;
    check("rst_cen",    32'(pc_cen),      32'd1);
    check("rst_req",    32'(imem_req),    32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    check("rst_err",    32'(err),         32'd0);
    check("rst_we",     32'(pc_we),       32'd0);
    check("rst_off",    32'(pc_offset),   32'd0);
    check("rst_instr",  32'(instr_o),     32'd0);
    check("rst_pc",     32'(imem_addr),   32'd0);

    rst = 1'b0;
    #1;
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_cen", 32'(pc_cen),   32'd0);
    imem_ack = 1'b1; instr_ready = 1'b1;
    tick(); #1;

    // Sequential loop: FETCH then ISSUE per instruction.
    for (int k = 0; k < 4; k++) begin
      check("seq_addr",  32'(imem_addr), 32'(k));
      check("seq_req",   32'(imem_req),  32'd1);
      check("seq_fwe",   32'(pc_we),     32'd0);
      check("seq_fcen",  32'(pc_cen),    32'd0);
      tick(); #1;
      check("seq_we",    32'(pc_we),     32'd1);
      check("seq_off",   32'(pc_offset), 32'd1);
      check("seq_cen",   32'(pc_cen),    32'd1);
      check("seq_instr", 32'(instr_o),   32'(word(12'(k))));
      tick(); #1;
    end
    tick(); tick(); #1;
    check("pre_br_addr", 32'(imem_addr), 32'd5);

    // Backward branch 5 + (-3) -> 2.
    tick();
    br_valid = 1'b1; br_offset = 12'hFFD;
    #1;
    check("br_we",  32'(pc_we),     32'd1);
    check("br_off", 32'(pc_offset), 32'hFFD);
    tick();
    br_valid = 1'b0;
    #1;
    check("br_addr",    32'(imem_addr), 32'd2);
    check("br_off_clr", 32'(pc_offset), 32'd0);
    check("br_we_clr",  32'(pc_we),     32'd0);

    // Wrap: branch 2 -> 4095, then sequential step wraps to 0.
    tick();
    br_valid = 1'b1; br_offset = 12'd4093;
    tick();
    br_valid = 1'b0;
    #1;
    check("wrap_top", 32'(imem_addr), 32'hFFF);
    tick(); tick(); #1;
    check("wrap_addr", 32'(imem_addr), 32'd0);
    check("wrap_err",  32'(err),       32'd0);

    // Zero branch offset re-fetches the same address.
    tick();
    br_valid = 1'b1; br_offset = 12'd0;
    #1;
    check("br0_we",  32'(pc_we),     32'd1);
    check("br0_off", 32'(pc_offset), 32'd0);
    tick();
    br_valid = 1'b0; imem_ack = 1'b0;
    #1;
    check("br0_addr", 32'(imem_addr), 32'd0);

    // Memory wait of 5 cycles.
    for (int i = 0; i < 5; i++) begin
      check("wait_req",   32'(imem_req),    32'd1);
      check("wait_valid", 32'(instr_valid), 32'd0);
      tick(); #1;
    end
    imem_ack = 1'b1;
    #1;
    check("ack_req", 32'(imem_req), 32'd1);
    tick();
    imem_ack = 1'b0; instr_ready = 1'b0; br_valid = 1'b1; halt_req = 1'b1;
    #1;
    // Backpressure: branch/halt requests outside accept must be ignored.
    for (int i = 0; i < 3; i++) begin
      check("bp_instr", 32'(instr_o),     32'(word(12'd0)));
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_we",    32'(pc_we),       32'd0);
      check("bp_cen",   32'(pc_cen),      32'd0);
      tick(); #1;
    end
    br_valid = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;
    #1;
    check("bp_acc_we",  32'(pc_we),     32'd1);
    check("bp_acc_off", 32'(pc_offset), 32'd1);
    tick(); #1;
    check("bp_next_addr", 32'(imem_addr), 32'd1);
    check("bp_halted",    32'(halted),    32'd0);

    // Timeout: 16 FETCH cycles without ack.
    for (int i = 0; i < 16; i++) begin
      check("tmo_req", 32'(imem_req), 32'd1);
      check("tmo_err", 32'(err),      32'd0);
      tick(); #1;
    end
    check("tmo_err_set", 32'(err),         32'd1);
    check("tmo_halted",  32'(halted),      32'd1);
    check("tmo_req_off", 32'(imem_req),    32'd0);
    check("tmo_valid",   32'(instr_valid), 32'd0);
    check("tmo_cen",     32'(pc_cen),      32'd0);
    imem_ack = 1'b1; instr_ready = 1'b1;
    tick(); tick(); #1;
    check("halt_stay", 32'(halted),   32'd1);
    check("err_stick", 32'(err),      32'd1);
    check("halt_req0", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_h_cen", 32'(pc_cen), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("rst_err_clr", 32'(err),       32'd0);
    check("rst_h_clr",   32'(halted),    32'd0);
    check("rst_h_pc",    32'(imem_addr), 32'd0);

    // Halt request outranks a branch on accept.
    tick(); tick();
    halt_req = 1'b1; br_valid = 1'b1; br_offset = 12'd5;
    #1;
    check("hlt_valid", 32'(instr_valid), 32'd1);
    check("hlt_we",    32'(pc_we),       32'd0);
    check("hlt_off",   32'(pc_offset),   32'd0);
    check("hlt_cen",   32'(pc_cen),      32'd0);
    tick();
    halt_req = 1'b0; br_valid = 1'b0;
    #1;
    check("hlt_state", 32'(halted),      32'd1);
    check("hlt_ivld",  32'(instr_valid), 32'd0);
    check("hlt_req",   32'(imem_req),    32'd0);
    check("hlt_pc",    32'(imem_addr),   32'd0);

    // Reset while a fetch is outstanding.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    #1;
    check("mid_pc1", 32'(imem_addr), 32'd1);
    imem_ack = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_cen", 32'(pc_cen), 32'd1);
    check("mid_we",  32'(pc_we),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_req",    32'(imem_req),    32'd0);
    check("mid_valid",  32'(instr_valid), 32'd0);
    check("mid_err",    32'(err),         32'd0);
    check("mid_halted", 32'(halted),      32'd0);
    check("mid_off",    32'(pc_offset),   32'd0);
    check("mid_instr",  32'(instr_o),     32'd0);
    check("mid_pc0",    32'(imem_addr),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
